distance1: RTL and testbench

- Signature-compare block for the LBIST flow.
- Compares the golden signature SIG_IN against the signature captured from the circuit under test, SIG_OUT, once per clock.
- Registers two results: the bitwise mismatch vector RED_SIG (SIG_IN XOR SIG_OUT) and its Hamming distance NUMBER (count of mismatching bits).
- Sits after the MISR/signature register and feeds the BIST pass/fail logic.

---
 rtl/distance1_pkg.sv | 15 +
 rtl/distance1_popcount_tree.sv | 33 +++
 rtl/distance1.sv | 56 +++++
 tb/tb_distance1.sv | 119 +++++++++++
 4 files changed

// File: rtl/distance1_pkg.sv
// Shared defaults and sizing helpers for the distance1 signature-compare block.
package distance1_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Leaf count of the adder tree: WIDTH rounded up to a power of two.
    function automatic int pow2_ceil(input int w);
        int p;
        p = 1;
        while (p < w) p = p * 2;
        return p;
    endfunction

endpackage

// File: rtl/distance1_popcount_tree.sv
// Combinational pairwise adder tree counting the set bits of vec_i.
// Purely combinational; zero latency, no flow control.
module popcount_tree
    import distance1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int LEAVES = pow2_ceil(WIDTH);

    logic [LEAVES-1:0] vec_pad;
    logic [CNT_W-1:0]  acc [LEAVES];

    assign vec_pad = LEAVES'(vec_i);

    // Each pass halves the live node count; acc[0] ends up holding the root.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            acc[i] = CNT_W'(vec_pad[i]);
        end
        for (int n = LEAVES; n > 1; n = n / 2) begin
            for (int i = 0; i < n / 2; i++) begin
                acc[i] = acc[2*i] + acc[2*i+1];
            end
        end
        cnt_o = acc[0];
    end

endmodule

// File: rtl/distance1.sv
// Registered signature compare: mismatch vector and Hamming distance, one-cycle latency.
// Optional DISTANCE1_ACCUM_EN turns NUMBER into a saturating running total.
module distance1
    import distance1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SIG_IN,
    input  logic [WIDTH-1:0] SIG_OUT,
    output logic [CNT_W-1:0] NUMBER,
    output logic [WIDTH-1:0] RED_SIG
);

    logic [WIDTH-1:0] red_sig_d, red_sig_q;
    logic [CNT_W-1:0] number_d, number_q;
    logic [CNT_W-1:0] pop_cnt;

    assign red_sig_d = SIG_IN ^ SIG_OUT;

    popcount_tree #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount_tree (
        .vec_i (red_sig_d),
        .cnt_o (pop_cnt)
    );

`ifdef DISTANCE1_ACCUM_EN
    logic [CNT_W:0] acc_sum;

    // One extra carry bit detects overflow so the total clamps instead of wrapping.
    always_comb begin
        acc_sum  = {1'b0, number_q} + {1'b0, pop_cnt};
        number_d = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
    end
`else
    assign number_d = pop_cnt;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            red_sig_q <= '0;
            number_q  <= '0;
        end else begin
            red_sig_q <= red_sig_d;
            number_q  <= number_d;
        end
    end

    assign RED_SIG = red_sig_q;
    assign NUMBER  = number_q;

endmodule

// File: tb/tb_distance1.sv
// Scoreboard bench for distance1; expectations come from an independent model.
module tb_distance1;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    typedef struct {
        logic [WIDTH-1:0] red;
        logic [CNT_W-1:0] num;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic [WIDTH-1:0] SIG_IN;
    logic [WIDTH-1:0] SIG_OUT;
    logic [CNT_W-1:0] NUMBER;
    logic [WIDTH-1:0] RED_SIG;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   model_acc;

    distance1 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SIG_IN  (SIG_IN),
        .SIG_OUT (SIG_OUT),
        .NUMBER  (NUMBER),
        .RED_SIG (RED_SIG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic step(input logic rst, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input string tag);
        exp_t e;
        exp_t o;
        int   pc;
        RST     = rst;
        SIG_IN  = a;
        SIG_OUT = b;
        pc = $countones(a ^ b);
        if (rst) begin
            model_acc = 0;
            e.red = '0;
            e.num = '0;
        end else begin
            e.red = a ^ b;
`ifdef DISTANCE1_ACCUM_EN
            model_acc = model_acc + pc;
            if (model_acc > 255) model_acc = 255;
            e.num = CNT_W'(model_acc);
`else
            e.num = CNT_W'(pc);
`endif
        end
        @(posedge CLK);
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            o = exp_q.pop_front();
            check({tag, "_red"}, 32'(RED_SIG), 32'(o.red));
            check({tag, "_num"}, 32'(NUMBER), 32'(o.num));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        model_acc = 0;
        RST       = 1'b1;
        SIG_IN    = '0;
        SIG_OUT   = '0;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) step(1'b1, 8'd54, 8'd22, "reset");

        step(1'b0, 8'd235, 8'd43, "t235_43");
        step(1'b0, 8'd35,  8'd53, "t35_53");
        step(1'b0, 8'd64,  8'd84, "t64_84");
        step(1'b0, 8'd20,  8'd63, "t20_63");
        step(1'b0, 8'hA5,  8'hA5, "equal");
        step(1'b0, 8'h00,  8'hFF, "complement");
        step(1'b1, 8'hFF,  8'h00, "mid_reset");
        step(1'b0, 8'h0F,  8'h00, "post_reset");

        step(1'b1, 8'd0, 8'd0, "rst2");
        for (int i = 0; i < 5; i++) step(1'b0, 8'd235, 8'd43, "hold235");

        step(1'b1, 8'd0, 8'd0, "rst3");
        for (int i = 0; i < 20; i++)
            step(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");

        step(1'b1, 8'd0, 8'd0, "rst4");
        for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 8'hFF, "sat");

        step(1'b1, 8'h12, 8'h34, "final_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
